// File: rtl/mul_ctrl_if.sv
// rtl/mul_ctrl_if.sv - request/response bundle between pipeline and multiply controller
interface mul_ctrl_if;
   logic [5:0]  op;
   logic        start;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        busy;
   logic        done;
   logic        stall;
   logic [31:0] hi_out;
   logic [31:0] lo_out;

   modport master (
      output op, start, src_a, src_b,
      input  busy, done, stall, hi_out, lo_out
   );

   modport slave (
      input  op, start, src_a, src_b,
      output busy, done, stall, hi_out, lo_out
   );
endinterface

// File: rtl/mul_ctrl.sv
// rtl/mul_ctrl.sv - 32x32 unsigned shift-add multiplier with Hi/Lo and multiply-accumulate
module mul_ctrl #(
   parameter logic [5:0] MULTU = 6'd25,
   parameter logic [5:0] MADDU = 6'd1,
   parameter logic [5:0] MFHI  = 6'd16,
   parameter logic [5:0] MFLO  = 6'd18
) (
   input  logic             clk,
   input  logic             rst,
   mul_ctrl_if.slave        bus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;

   logic [1:0]  state_q,  state_d;
   logic [4:0]  count_q,  count_d;
   logic [63:0] mcand_q,  mcand_d;
   logic [31:0] mplier_q, mplier_d;
   logic [5:0]  op_q,     op_d;
   logic [63:0] prod_q,   prod_d;
   logic [63:0] hilo_q,   hilo_d;
   logic        busy_q,   busy_d;
   logic        done_q,   done_d;

   logic start_ok;
   assign start_ok = bus.start && ((bus.op == MULTU) || (bus.op == MADDU));

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      op_d     = op_q;
      prod_d   = prod_q;
      hilo_d   = hilo_q;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_ok) begin
               mcand_d  = {32'd0, bus.src_a};
               mplier_d = bus.src_b;
               op_d     = bus.op;
               prod_d   = 64'd0;
               count_d  = 5'd0;
               state_d  = S_RUN;
            end
         end
         S_RUN: begin
            if (mplier_q[0]) begin
               prod_d = prod_q + mcand_q;
            end
            mplier_d = mplier_q >> 1;
            mcand_d  = mcand_q << 1;
            count_d  = count_q + 5'd1;
            if (count_q == 5'd31) begin
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            // Accumulate wraps at 2^64; the carry out is intentionally dropped.
            hilo_d  = (op_q == MADDU) ? (hilo_q + prod_q) : prod_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d == S_RUN) || (state_d == S_WRITE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         count_q  <= 5'd0;
         mcand_q  <= 64'd0;
         mplier_q <= 32'd0;
         op_q     <= 6'd0;
         prod_q   <= 64'd0;
         hilo_q   <= 64'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         op_q     <= op_d;
         prod_q   <= prod_d;
         hilo_q   <= hilo_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // Stall looks at the live op so a dependent Hi/Lo access waits for the result.
   assign bus.stall  = busy_q && ((bus.op == MULTU) || (bus.op == MADDU) ||
                                  (bus.op == MFHI)  || (bus.op == MFLO));
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.hi_out = hilo_q[63:32];
   assign bus.lo_out = hilo_q[31:0];

endmodule
